// File: rtl/hxmpp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hxmpp_scheduler_pkg
// Description : Shared HXMPP parameters: scheduler FSM state encoding and the
//               width of the datapath write-credit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package hxmpp_scheduler_pkg;

    // Bits needed to index the datapath hit-info queue. The credit counter
    // is one bit wider so it can hold the full queue size.
    localparam int QUEUESIZEBITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

endpackage : hxmpp_scheduler_pkg
`default_nettype wire

// File: rtl/hit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : hit_fifo
// Description : Small synchronous FIFO for incoming hits. Pointers carry an
//               extra wrap bit so full and empty are distinguished without
//               an occupancy counter. Head data is read combinationally.
// Revision    : 1.0 - initial release
// Ports       : clk, reset (async, active-low)
//               push_i/din_i   - write one entry (caller guarantees !full)
//               pop_i          - drop head entry (caller guarantees !empty)
//               dout_o         - current head entry
//               full_o/empty_o - status
// ============================================================================
module hit_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    // Same slot but different lap -> writer is a full buffer ahead.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule : hit_fifo
`default_nettype wire

// File: rtl/hxmpp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hxmpp_scheduler
// Description : Buffers hits, issues credit-limited writes to the datapath,
//               waits for the datapath to go quiet after an event ends, then
//               forwards readout requests until the last one.
// Revision    : 1.0 - initial release
// Ports       : clk, reset (async, active-low)
//               hit_*          - incoming hit stream (valid/ready)
//               rd_*           - readout request stream (valid/ready)
//               event_end      - end-of-event pulse
//               dp_*           - datapath status inputs
//               write*/read*   - registered datapath commands
//               state, credits, event_done - status
// ============================================================================
module hxmpp_scheduler
    import hxmpp_scheduler_pkg::*;
#(
    parameter int ROWINDEXBITS_HCM = 10,
    parameter int HITINFOBITS      = 32,
    parameter int QUEUESIZE        = 8,
    parameter int FIFODEPTH        = 4,
    parameter int DRAINWAIT        = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        hit_valid,
    input  logic [ROWINDEXBITS_HCM-1:0] hit_ssid,
    input  logic [HITINFOBITS-1:0]      hit_info,
    output logic                        hit_ready,
    input  logic                        rd_valid,
    input  logic [ROWINDEXBITS_HCM-1:0] rd_ssid,
    input  logic                        rd_last,
    output logic                        rd_ready,
    input  logic                        event_end,
    input  logic                        dp_writeReady,
    input  logic                        dp_readReady,
    input  logic                        dp_busy,
    input  logic                        dp_done,
    output logic                        write,
    output logic [ROWINDEXBITS_HCM-1:0] writeSSID,
    output logic [HITINFOBITS-1:0]      writeHitInfo,
    output logic                        read,
    output logic [ROWINDEXBITS_HCM-1:0] readSSID,
    output logic [1:0]                  state,
    output logic [QUEUESIZEBITS:0]      credits,
    output logic                        event_done
);

    localparam int FW  = ROWINDEXBITS_HCM + HITINFOBITS;
    localparam int CW  = QUEUESIZEBITS + 1;
    localparam int DCW = $clog2(DRAINWAIT + 1);

    localparam logic [CW-1:0]  CRED_MAX  = CW'(QUEUESIZE);
    localparam logic [CW-1:0]  CRED_ONE  = CW'(1);
    localparam logic [DCW-1:0] DRAIN_END = DCW'(DRAINWAIT - 1);
    localparam logic [DCW-1:0] DRAIN_ONE = DCW'(1);

    state_t                      state_q, state_d;
    logic [CW-1:0]               credits_q, credits_d;
    logic [DCW-1:0]              drain_cnt_q, drain_cnt_d;
    logic                        err_underflow_q, err_underflow_d;
    logic                        ready_en_q;
    logic                        write_q, write_d;
    logic [ROWINDEXBITS_HCM-1:0] wssid_q, wssid_d;
    logic [HITINFOBITS-1:0]      winfo_q, winfo_d;
    logic                        read_q, read_d;
    logic [ROWINDEXBITS_HCM-1:0] rssid_q, rssid_d;
    logic                        event_done_q, event_done_d;

    logic          fifo_push;
    logic          fifo_pop;
    logic [FW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          issue;
    logic          done_ok;
    logic          rd_accept;
    logic          drain_idle;

    hit_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFODEPTH)
    ) u_hit_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   ({hit_ssid, hit_info}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ready_en_q keeps hit_ready low until the first edge after reset release.
    assign hit_ready = ready_en_q && !fifo_full &&
                       ((state_q == ST_IDLE) || (state_q == ST_FILL));
    assign fifo_push = hit_valid && hit_ready;

    assign issue     = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) &&
                       !fifo_empty && dp_writeReady && (credits_q < CRED_MAX);
    assign fifo_pop  = issue;

    // A completion with nothing outstanding is dropped and flagged.
    assign done_ok   = dp_done && (credits_q != '0);

    assign rd_ready  = (state_q == ST_READOUT) && dp_readReady;
    assign rd_accept = rd_valid && rd_ready;

    assign drain_idle = fifo_empty && (credits_q == '0) && !dp_busy;

    always_comb begin
        state_d         = state_q;
        drain_cnt_d     = '0;
        credits_d       = credits_q;
        err_underflow_d = err_underflow_q | (dp_done && (credits_q == '0));
        write_d         = issue;
        wssid_d         = issue ? fifo_dout[FW-1 -: ROWINDEXBITS_HCM] : wssid_q;
        winfo_d         = issue ? fifo_dout[HITINFOBITS-1:0] : winfo_q;
        read_d          = rd_accept;
        rssid_d         = rd_accept ? rd_ssid : rssid_q;
        event_done_d    = rd_accept && rd_last;

        case ({issue, done_ok})
            2'b10:   credits_d = credits_q + CRED_ONE;
            2'b01:   credits_d = credits_q - CRED_ONE;
            default: credits_d = credits_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (event_end) begin
                    state_d = ST_DRAIN;
                end else if (fifo_push) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (event_end) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Any non-idle cycle restarts the quiet-period count.
                if (drain_idle) begin
                    if (drain_cnt_q == DRAIN_END) begin
                        state_d = ST_READOUT;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DRAIN_ONE;
                    end
                end
            end
            ST_READOUT: begin
                if (rd_accept && rd_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            credits_q       <= '0;
            drain_cnt_q     <= '0;
            err_underflow_q <= 1'b0;
            ready_en_q      <= 1'b0;
            write_q         <= 1'b0;
            wssid_q         <= '0;
            winfo_q         <= '0;
            read_q          <= 1'b0;
            rssid_q         <= '0;
            event_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            credits_q       <= credits_d;
            drain_cnt_q     <= drain_cnt_d;
            err_underflow_q <= err_underflow_d;
            ready_en_q      <= 1'b1;
            write_q         <= write_d;
            wssid_q         <= wssid_d;
            winfo_q         <= winfo_d;
            read_q          <= read_d;
            rssid_q         <= rssid_d;
            event_done_q    <= event_done_d;
        end
    end

    assign state        = state_q;
    assign credits      = credits_q;
    assign write        = write_q;
    assign writeSSID    = wssid_q;
    assign writeHitInfo = winfo_q;
    assign read         = read_q;
    assign readSSID     = rssid_q;
    assign event_done   = event_done_q;

endmodule : hxmpp_scheduler
`default_nettype wire

// File: tb/tb_hxmpp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hxmpp_scheduler
// Description : Self-checking bench for hxmpp_scheduler: directed scenarios
//               plus a randomized run against an in-order hit queue and a
//               credit count derived from observed writes and completions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hxmpp_scheduler;

    localparam int RB = 10;
    localparam int IB = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          hit_valid;
    logic [RB-1:0] hit_ssid;
    logic [IB-1:0] hit_info;
    logic          hit_ready;
    logic          rd_valid;
    logic [RB-1:0] rd_ssid;
    logic          rd_last;
    logic          rd_ready;
    logic          event_end;
    logic          dp_writeReady, dp_readReady, dp_busy, dp_done;
    logic          write;
    logic [RB-1:0] writeSSID;
    logic [IB-1:0] writeHitInfo;
    logic          read;
    logic [RB-1:0] readSSID;
    logic [1:0]    state;
    logic [3:0]    credits;
    logic          event_done;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted hits in arrival order, outstanding credits.
    logic [RB+IB-1:0] mq[$];
    int               mc;

    always #5 clk = ~clk;

    hxmpp_scheduler #(
        .ROWINDEXBITS_HCM (RB),
        .HITINFOBITS      (IB),
        .QUEUESIZE        (8),
        .FIFODEPTH        (4),
        .DRAINWAIT        (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .hit_valid     (hit_valid),
        .hit_ssid      (hit_ssid),
        .hit_info      (hit_info),
        .hit_ready     (hit_ready),
        .rd_valid      (rd_valid),
        .rd_ssid       (rd_ssid),
        .rd_last       (rd_last),
        .rd_ready      (rd_ready),
        .event_end     (event_end),
        .dp_writeReady (dp_writeReady),
        .dp_readReady  (dp_readReady),
        .dp_busy       (dp_busy),
        .dp_done       (dp_done),
        .write         (write),
        .writeSSID     (writeSSID),
        .writeHitInfo  (writeHitInfo),
        .read          (read),
        .readSSID      (readSSID),
        .state         (state),
        .credits       (credits),
        .event_done    (event_done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one cycle; update the model from what crossed the edge.
    task automatic tick();
        logic             acc;
        logic             dn;
        logic [RB+IB-1:0] hv;
        int               m0;
        acc = hit_valid && hit_ready;
        dn  = dp_done;
        hv  = {hit_ssid, hit_info};
        @(posedge clk);
        #1;
        if (!reset) begin
            mq.delete();
            mc = 0;
        end else begin
            if (acc) mq.push_back(hv);
            m0 = mc;
            mc = m0 + (write ? 1 : 0) - ((dn && m0 > 0) ? 1 : 0);
        end
    endtask

    task automatic clear_inputs();
        hit_valid = 0; hit_ssid = '0; hit_info = '0;
        rd_valid = 0; rd_ssid = '0; rd_last = 0; event_end = 0;
        dp_writeReady = 0; dp_readReady = 0; dp_busy = 0; dp_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1;
        mq.delete();
        mc = 0;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (state !== 2'd0 || credits !== 4'd0) begin
            errors++;
            $display("FAIL reset_state_credits: state=%0d credits=%0d, required 0/0", state, credits);
        end
        checks++;
        if ({write, read, event_done, hit_ready, rd_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: write/read/event_done/hit_ready/rd_ready=%b, required 00000",
                     {write, read, event_done, hit_ready, rd_ready});
        end
        checks++;
        if (writeSSID !== '0 || writeHitInfo !== '0 || readSSID !== '0) begin
            errors++;
            $display("FAIL reset_data: wssid=%0h winfo=%0h rssid=%0h, required 0", writeSSID, writeHitInfo, readSSID);
        end
        reset = 1;
        mq.delete();
        mc = 0;
        #1;
        checks++;
        if (hit_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: hit_ready=%b, required 0", hit_ready);
        end
        tick();
        checks++;
        if (hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: hit_ready=%b, required 1", hit_ready);
        end
    endtask

    task automatic test_three_hits();
        logic exp_w;
        dp_writeReady = 1;
        for (int i = 0; i < 7; i++) begin
            hit_valid = (i < 3);
            hit_ssid  = RB'(5 + i);
            hit_info  = IB'(10 + i);
            tick();
            // Now in cycle i+1; hit k lands on write in cycle k+2.
            exp_w = (i + 1 >= 2) && (i + 1 <= 4);
            checks++;
            if (write !== exp_w) begin
                errors++;
                $display("FAIL three_hits_write c%0d: write=%b, required %b", i + 1, write, exp_w);
            end
            if (exp_w) begin
                checks++;
                if (writeSSID !== RB'(5 + i - 1) || writeHitInfo !== IB'(10 + i - 1)) begin
                    errors++;
                    $display("FAIL three_hits_data c%0d: ssid=%0d info=%0h, required %0d/%0h",
                             i + 1, writeSSID, writeHitInfo, 5 + i - 1, 10 + i - 1);
                end
            end
        end
        hit_valid = 0;
        checks++;
        if (credits !== 4'd3 || state !== 2'd1) begin
            errors++;
            $display("FAIL three_hits_end: credits=%0d state=%0d, required 3/1", credits, state);
        end
    endtask

    task automatic test_same_cycle();
        hit_valid = 1; hit_ssid = RB'(51); hit_info = IB'(32'h33);
        tick();
        hit_valid = 0;
        dp_done   = 1;   // coincides with the cycle the write is issued
        tick();
        dp_done   = 0;
        checks++;
        if (write !== 1'b1 || credits !== 4'd3) begin
            errors++;
            $display("FAIL same_cycle: write=%b credits=%0d, required 1/3", write, credits);
        end
        tick();
        checks++;
        if (credits !== 4'd3) begin
            errors++;
            $display("FAIL same_cycle_hold: credits=%0d, required 3", credits);
        end
    endtask

    task automatic test_back_to_back();
        int   nw;
        int   nw2;
        logic ready_ok;
        do_reset();
        dp_writeReady = 1;
        nw = 0;
        ready_ok = 1;
        for (int i = 0; i < 10; i++) begin
            hit_valid = 1; hit_ssid = RB'($urandom); hit_info = $urandom;
            if (hit_ready !== 1'b1) ready_ok = 0;
            tick();
            if (write) nw++;
        end
        hit_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (write) nw++;
        end
        checks++;
        if (!ready_ok) begin
            errors++;
            $display("FAIL b2b_ready: hit_ready dropped, required 1 for all ten hits");
        end
        checks++;
        if (nw != 8 || credits !== 4'd8) begin
            errors++;
            $display("FAIL b2b_writes: writes=%0d credits=%0d, required 8/8", nw, credits);
        end
        for (int i = 0; i < 2; i++) begin
            hit_valid = 1; hit_ssid = RB'($urandom); hit_info = $urandom;
            tick();
            if (write) nw++;
        end
        hit_valid = 0;
        checks++;
        if (hit_ready !== 1'b0 || nw != 8) begin
            errors++;
            $display("FAIL b2b_full: hit_ready=%b writes=%0d, required 0/8", hit_ready, nw);
        end
        dp_done = 1;
        tick();
        dp_done = 0;
        nw2 = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (write) begin
                nw2++;
                checks++;
                if ({writeSSID, writeHitInfo} !== mq[8]) begin
                    errors++;
                    $display("FAIL b2b_release_data: got %0h, required %0h", {writeSSID, writeHitInfo}, mq[8]);
                end
            end
        end
        checks++;
        if (nw2 != 1 || credits !== 4'd8) begin
            errors++;
            $display("FAIL b2b_release: writes=%0d credits=%0d, required 1/8", nw2, credits);
        end
    endtask

    task automatic test_drain();
        int   nw;
        int   k;
        logic early;
        do_reset();
        dp_writeReady = 1;
        nw = 0;
        hit_valid = 1; hit_ssid = RB'(1); hit_info = IB'(1);
        tick();
        hit_valid = 1; hit_ssid = RB'(2); hit_info = IB'(2); event_end = 1;
        checks++;
        if (hit_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_hit_with_end: hit_ready=%b, required 1", hit_ready);
        end
        tick();
        hit_valid = 0; event_end = 0;
        if (write) nw++;
        checks++;
        if (state !== 2'd2 || hit_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_enter: state=%0d hit_ready=%b, required 2/0", state, hit_ready);
        end
        hit_valid = 1; hit_ssid = RB'(3); hit_info = IB'(3);   // must be refused
        tick();
        hit_valid = 0;
        if (write) nw++;
        tick();
        if (write) nw++;
        checks++;
        if (nw != 2 || credits !== 4'd2) begin
            errors++;
            $display("FAIL drain_writes: writes=%0d credits=%0d, required 2/2", nw, credits);
        end
        dp_done = 1;
        tick();
        tick();
        dp_done = 0;
        k = 0;
        while (credits !== 4'd0 && k < 10) begin
            tick();
            k++;
        end
        checks++;
        if (credits !== 4'd0) begin
            errors++;
            $display("FAIL drain_credits_return: credits=%0d, required 0", credits);
        end
        early = 0;
        for (int i = 0; i < 8; i++) begin
            if (state !== 2'd2) early = 1;
            tick();
            if (write) nw++;
        end
        dp_busy = 1;
        tick();
        dp_busy = 0;
        for (int i = 0; i < 16; i++) begin
            if (state !== 2'd2) early = 1;
            tick();
            if (write) nw++;
        end
        checks++;
        if (early) begin
            errors++;
            $display("FAIL drain_restart: state left DRAIN early, required 2 until 16 quiet cycles");
        end
        checks++;
        if (state !== 2'd3 || nw != 2) begin
            errors++;
            $display("FAIL drain_readout: state=%0d writes=%0d, required 3/2", state, nw);
        end
    endtask

    task automatic test_readout();
        dp_readReady = 0;
        #1;
        checks++;
        if (rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL rd_ready_low: rd_ready=%b, required 0", rd_ready);
        end
        dp_readReady = 1;
        #1;
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_ready_high: rd_ready=%b, required 1", rd_ready);
        end
        rd_valid = 1; rd_ssid = RB'(9); rd_last = 0;
        tick();
        checks++;
        if (read !== 1'b1 || readSSID !== RB'(9) || event_done !== 1'b0 || state !== 2'd3) begin
            errors++;
            $display("FAIL read_first: read=%b ssid=%0d done=%b state=%0d, required 1/9/0/3",
                     read, readSSID, event_done, state);
        end
        rd_ssid = RB'(12); rd_last = 1;
        tick();
        checks++;
        if (read !== 1'b1 || readSSID !== RB'(12) || event_done !== 1'b1 || state !== 2'd0) begin
            errors++;
            $display("FAIL read_last: read=%b ssid=%0d done=%b state=%0d, required 1/12/1/0",
                     read, readSSID, event_done, state);
        end
        rd_valid = 0; rd_last = 0;
        tick();
        checks++;
        if (read !== 1'b0 || event_done !== 1'b0 || rd_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_after: read=%b done=%b rd_ready=%b, required 0/0/0", read, event_done, rd_ready);
        end
        dp_readReady = 0;
    endtask

    task automatic test_async_reset();
        int nw;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            hit_valid = 1; hit_ssid = RB'(20 + i); hit_info = IB'(40 + i);
            dp_writeReady = 1;
            tick();
        end
        hit_valid = 0;
        dp_writeReady = 0;
        checks++;
        if (write !== 1'b1 || credits !== 4'd3) begin
            errors++;
            $display("FAIL areset_pre: write=%b credits=%0d, required 1/3", write, credits);
        end
        #2;
        reset = 0;
        #1;
        checks++;
        if (write !== 1'b0 || credits !== 4'd0 || state !== 2'd0 || hit_ready !== 1'b0 ||
            writeSSID !== '0 || writeHitInfo !== '0) begin
            errors++;
            $display("FAIL areset_async: write=%b credits=%0d state=%0d ready=%b wssid=%0d winfo=%0h, required all 0",
                     write, credits, state, hit_ready, writeSSID, writeHitInfo);
        end
        @(posedge clk);
        #1;
        reset = 1;
        mq.delete();
        mc = 0;
        dp_writeReady = 1;
        tick();
        hit_valid = 1; hit_ssid = RB'(341); hit_info = IB'(32'h55);
        tick();
        hit_valid = 0;
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (write) begin
                nw++;
                checks++;
                if (writeSSID !== RB'(341) || writeHitInfo !== IB'(32'h55)) begin
                    errors++;
                    $display("FAIL areset_stale: ssid=%0d info=%0h, required 341/55", writeSSID, writeHitInfo);
                end
            end
        end
        checks++;
        if (nw != 1 || credits !== 4'd1) begin
            errors++;
            $display("FAIL areset_after: writes=%0d credits=%0d, required 1/1", nw, credits);
        end
    endtask

    task automatic test_random();
        logic             racc;
        logic [RB-1:0]    rs;
        logic [RB+IB-1:0] exp;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            hit_valid     = $urandom_range(0, 1);
            hit_ssid      = RB'($urandom);
            hit_info      = $urandom;
            dp_writeReady = ($urandom_range(0, 3) != 0);
            dp_done       = ($urandom_range(0, 2) == 0);
            event_end     = ($urandom_range(0, 29) == 0);
            dp_busy       = ($urandom_range(0, 7) == 0);
            dp_readReady  = $urandom_range(0, 1);
            rd_valid      = $urandom_range(0, 1);
            rd_ssid       = RB'($urandom);
            rd_last       = ($urandom_range(0, 3) == 0);
            #1;
            racc = rd_valid && rd_ready;
            rs   = rd_ssid;
            tick();
            if (write) begin
                checks++;
                if (mq.size() == 0) begin
                    errors++;
                    $display("FAIL rand_write_order n%0d: write with no pending hit", n);
                end else begin
                    exp = mq.pop_front();
                    if ({writeSSID, writeHitInfo} !== exp) begin
                        errors++;
                        $display("FAIL rand_write_order n%0d: got %0h, required %0h", n, {writeSSID, writeHitInfo}, exp);
                    end
                end
            end
            checks++;
            if (credits !== 4'(mc) || mc > 8) begin
                errors++;
                $display("FAIL rand_credits n%0d: credits=%0d, required %0d (max 8)", n, credits, mc);
            end
            checks++;
            if (read !== racc || (racc && readSSID !== rs)) begin
                errors++;
                $display("FAIL rand_read n%0d: read=%b ssid=%0d, required %b/%0d", n, read, readSSID, racc, rs);
            end
            if (state == 2'd3 && write) begin
                errors++;
                $display("FAIL rand_write_in_readout n%0d: write=1, required 0", n);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        mc = 0;
        test_reset();
        test_three_hits();
        test_same_cycle();
        test_back_to_back();
        test_drain();
        test_readout();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_hxmpp_scheduler
`default_nettype wire

// File: doc/hxmpp_scheduler.md
HXMPP_SCHEDULER -- requirements
Module: hxmpp_scheduler

Interface
REQ-001 Parameter ROWINDEXBITS_HCM, default 10: SSID width on the hit, read-request and datapath ports.
REQ-002 Parameter HITINFOBITS, default 32: hit-info width.
REQ-003 Parameter QUEUESIZE, default 8: maximum number of datapath writes in flight (depth of the datapath hit-info queue).
REQ-004 Parameter FIFODEPTH, default 4 (power of two): depth of the internal hit FIFO.
REQ-005 Parameter DRAINWAIT, default 16: number of consecutive idle-datapath cycles required before readout.
REQ-006 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Ports hit_valid (input, 1), hit_ssid (input, ROWINDEXBITS_HCM), hit_info (input, HITINFOBITS), hit_ready (output, 1): incoming hit stream.
REQ-009 Ports rd_valid (input, 1), rd_ssid (input, ROWINDEXBITS_HCM), rd_last (input, 1), rd_ready (output, 1): readout request stream.
REQ-010 Port event_end, input, 1: single-cycle pulse marking the end of an event's hits.
REQ-011 Ports dp_writeReady, dp_readReady, dp_busy, dp_done (input, 1 each): datapath status; dp_done pulses once per completed write.
REQ-012 Ports write (output, 1), writeSSID (output, ROWINDEXBITS_HCM), writeHitInfo (output, HITINFOBITS), read (output, 1), readSSID (output, ROWINDEXBITS_HCM): datapath commands.
REQ-013 Ports state (output, 2), credits (output, QUEUESIZEBITS+1), event_done (output, 1): status.

Function
REQ-014 The FSM shall have four states: IDLE=0, FILL=1, DRAIN=2, READOUT=3, and the state output shall reflect the current state.
REQ-015 IDLE shall go to FILL on the first accepted hit, and to DRAIN on event_end.
REQ-016 The hit FIFO shall accept a hit when hit_valid && hit_ready, with hit_ready = FIFO not full && state in {IDLE, FILL}.
REQ-017 A write shall issue when state is FILL or DRAIN && the FIFO is non-empty && dp_writeReady && credits < QUEUESIZE; it pops the FIFO head.
REQ-018 write shall be registered and high for exactly one cycle per issue, with writeSSID/writeHitInfo valid in the same cycle; at most one write per cycle.
REQ-019 Hit-to-write latency shall be 2 cycles minimum: a hit accepted at cycle N drives write at cycle N+2 when the FIFO was empty and all conditions hold.
REQ-020 credits shall increment on each issued write and decrement on each dp_done; a write and dp_done in the same cycle shall leave credits unchanged.
REQ-021 A dp_done while credits==0 shall be ignored, with no underflow, and shall set the sticky internal flag err_underflow.
REQ-022 event_end in IDLE or FILL shall move the FSM to DRAIN on the next cycle; event_end in DRAIN or READOUT shall be ignored.
REQ-023 A hit offered in the cycle event_end is sampled shall still be accepted when hit_ready is high; no hits shall be accepted in DRAIN.
REQ-024 DRAIN shall count consecutive cycles with FIFO empty && credits==0 && !dp_busy; the count shall clear whenever the condition fails.
REQ-025 DRAIN shall go to READOUT when the count reaches DRAINWAIT.
REQ-026 In READOUT, rd_ready shall equal dp_readReady.
REQ-027 In READOUT, on rd_valid && rd_ready, read shall pulse for one cycle on the next cycle with readSSID = rd_ssid.
REQ-028 An accepted request with rd_last=1 shall return the FSM to IDLE in the same cycle its read pulses, and event_done shall pulse in that cycle.
REQ-029 rd_ready shall be 0 outside READOUT, and write shall never assert in READOUT.
REQ-030 A FIFO full-and-empty boundary shall use an extra wrap bit on the pointers; a simultaneous push and pop on a full FIFO is not possible because hit_ready=0 when full.

Reset
REQ-031 While reset is low, state=IDLE, credits=0, the FIFO pointers and drain counter=0, err_underflow=0, and write, read, event_done, hit_ready and rd_ready=0, with writeSSID, writeHitInfo and readSSID=0.
REQ-032 Reset asserted mid-operation shall discard FIFO contents and in-flight credits immediately, without waiting for the clock.
REQ-033 hit_ready shall rise on the first clock edge after reset deasserts.

Structure
REQ-034 The FSM state encoding and QUEUESIZEBITS shall live in the shared parameter include used by the HXMPP blocks.
REQ-035 The hit FIFO shall be a separate sub-module, hit_fifo, parameterised by width and depth; the FSM, credit counter and drain counter shall stay in hxmpp_scheduler.

Verification
REQ-036 Three hits (ssid 5, 6, 7; info 0xA, 0xB, 0xC) with dp_writeReady=1 -> write pulses on three consecutive cycles, carrying the values in order, and credits reaches 3.
REQ-037 Ten back-to-back hits with dp_done held low -> exactly 8 writes, credits=8 and hit_ready=0 once the FIFO holds 4; one dp_done then releases exactly one write.
REQ-038 Write issue and dp_done in the same cycle at credits=3 -> credits stays 3.
REQ-039 event_end with 2 hits queued -> 2 writes, then after the credits return to 0 and DRAINWAIT=16 idle cycles, state=3; a dp_busy glitch during the count restarts it.
REQ-040 In READOUT, requests ssid 9 then ssid 12 with rd_last -> read pulses with readSSID 9 then 12, event_done pulses once, and state returns to 0.
REQ-041 Reset pulled low mid-FILL with 3 credits -> all outputs are 0 asynchronously; after release, credits=0 and no stale write issues.
